load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side controller for the word-organised data memory.
- Takes one load/store request at a time from the execute stage and drives the memory's write enable, read enable, address and write-data.
- Extracts and sign/zero-extends load data.
- Implements byte and halfword stores as a two-cycle read-modify-write, because the memory writes whole words only.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the data memory; word index >= MEM_WORDS is out of range.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_is_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_error  output  1  valid with resp_valid; misaligned, illegal funct3 or out-of-range access.
resp_rdata  output  32  extended load data; 0 for stores and errors.
mem_write_enable  output  1  memory write strobe.
mem_read_enable  output  1  memory read strobe.
mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}.
mem_write_data  output  32  full word to write.
mem_read_data  input  32  memory read data; combinational from mem_addr when mem_read_enable=1.

Behaviour:
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Reset (async) forces IDLE and clears the captured request and merge registers. While reset is high, all outputs are 0 except req_ready=0.
- After reset release:
  - req_ready=1 only in IDLE.
  - resp_valid, resp_error, resp_rdata, mem_* all 0 outside their active states.
- Accept: in IDLE, req_valid=1 at a rising edge captures is_store, funct3, addr and wdata. The inputs are ignored at all other times.
- Decode at accept:
  - Error if the funct3 is illegal for the direction: stores allow only 000/001/010; loads allow 000/001/010/100/101.
  - Error if halfword and addr[0]=1.
  - Error if word and addr[1:0]!=0.
  - Error if addr[31:2] >= MEM_WORDS.
  - On error: go directly to RESP with no memory strobe.
- Next state after accept (no error):
  - Load -> LOAD.
  - SW -> STORE.
  - SB/SH -> RMW_RD.
- LOAD (1 cycle):
  - mem_read_enable=1, mem_addr driven.
  - Select byte addr[1:0] or half addr[1]. Sign-extend for 000/001, zero-extend for 100/101, pass through for 010.
  - Register the result, then go to RESP.
- STORE (1 cycle): mem_write_enable=1, mem_write_data=wdata. Memory writes at the closing edge. Then RESP.
- RMW_RD (1 cycle):
  - mem_read_enable=1.
  - Merge: replace byte lane addr[1:0] with wdata[7:0] (SB), or half lane addr[1] with wdata[15:0] (SH).
  - Register the merged word, then RMW_WR.
- RMW_WR (1 cycle): mem_write_enable=1, mem_write_data=merged word. Then RESP.
- RESP (1 cycle): resp_valid=1 with resp_error and resp_rdata, then IDLE. There is no response backpressure.
- Latency (accept edge = edge 0; resp_valid high in cycle N):
  - Error: N=1.
  - Load/SW: N=2.
  - SB/SH: N=3.
- The next request is accepted at the edge ending RESP+1 (IDLE cycle); throughput is one request per N+1 cycles.
- mem_read_enable and mem_write_enable are never both 1.
- Each enable is high for exactly one cycle per access.
- Reset mid-operation: outputs drop asynchronously and any pending RMW write is abandoned (memory word unchanged). No resp_valid is issued for the aborted request.

Test Plan:
1. Preload word 0x10 = 0x8899AABB. LW addr 0x10 -> mem_read_enable high 1 cycle, mem_addr=0x10; resp_valid in cycle 2, resp_rdata=0x8899AABB, resp_error=0.
2. Extension checks on the same word:
   - LB 0x13 -> 0xFFFFFF88.
   - LBU 0x13 -> 0x00000088.
   - LH 0x12 -> 0xFFFF8899.
   - LHU 0x10 -> 0x0000AABB.
   - LB 0x10 -> 0xFFFFFFBB.
3. SB addr 0x11, wdata 0x123456CC -> read cycle, then one write cycle with mem_write_data=0x8899CCBB; resp_valid in cycle 3; a following LW 0x10 returns 0x8899CCBB. SW 0x14 of 0xDEADBEEF -> single write, resp in cycle 2.
4. Errors, each giving resp_error=1 in cycle 1, resp_rdata=0 and no mem strobe:
   - SH 0x11.
   - LW 0x402.
   - LW 0x400 (word 256, MEM_WORDS=256).
   - Store with funct3=100.
5. Start SH 0x12, wdata 0x7777. Assert reset during RMW_WR -> mem_write_enable falls the same cycle, word 0x10 is unchanged, no resp_valid; after release req_ready=1.
6. Hold req_valid=1 with two LWs back-to-back -> second accepted only in the IDLE cycle after the first RESP; req_ready=0 during LOAD/RESP; both results correct.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-at-a-time load/store controller for a word-organised data memory
// Byte/halfword stores are a read-modify-write because the memory only writes whole words.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state, state_next;
    logic        st_store;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [31:0] merged_q;

    logic        f3_legal, misaligned, out_of_range, dec_error;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Decode works on the live request inputs so the error is known at the accept edge.
    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_is_store;
            default:                f3_legal = 1'b0;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
        dec_error    = !f3_legal || misaligned || out_of_range;
    end

    always_comb begin
        byte_sel = 8'h00;
        case (st_addr[1:0])
            2'd0: byte_sel = mem_read_data[7:0];
            2'd1: byte_sel = mem_read_data[15:8];
            2'd2: byte_sel = mem_read_data[23:16];
            2'd3: byte_sel = mem_read_data[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = st_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (st_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            3'b101:  load_data = {16'h0000, half_sel};
            default: load_data = mem_read_data;
        endcase
    end

    always_comb begin
        merged_word = mem_read_data;
        if (st_funct3[1:0] == 2'b00) begin
            case (st_addr[1:0])
                2'd0: merged_word[7:0]   = st_wdata[7:0];
                2'd1: merged_word[15:8]  = st_wdata[7:0];
                2'd2: merged_word[23:16] = st_wdata[7:0];
                2'd3: merged_word[31:24] = st_wdata[7:0];
                default: merged_word = mem_read_data;
            endcase
        end else if (st_addr[1]) begin
            merged_word[31:16] = st_wdata[15:0];
        end else begin
            merged_word[15:0] = st_wdata[15:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (dec_error)               state_next = RESP;
                    else if (!req_is_store)      state_next = LOAD;
                    else if (req_funct3 == 3'b010) state_next = STORE;
                    else                         state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            STORE:   state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            st_store  <= 1'b0;
            st_funct3 <= 3'b000;
            st_addr   <= 32'h0;
            st_wdata  <= 32'h0;
            rdata_q   <= 32'h0;
            error_q   <= 1'b0;
            merged_q  <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_store  <= req_is_store;
                        st_funct3 <= req_funct3;
                        st_addr   <= req_addr;
                        st_wdata  <= req_wdata;
                        rdata_q   <= 32'h0;
                        error_q   <= dec_error;
                    end
                end
                LOAD:    rdata_q  <= load_data;
                RMW_RD:  merged_q <= merged_word;
                default: ;
            endcase
        end
    end

    // Outputs decode from state alone; async reset of state drops them immediately.
    always_comb begin
        req_ready        = (state == IDLE) && !reset;
        resp_valid       = 1'b0;
        resp_error       = 1'b0;
        resp_rdata       = 32'h0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_addr         = 32'h0;
        mem_write_data   = 32'h0;
        case (state)
            LOAD, RMW_RD: begin
                mem_read_enable = 1'b1;
                mem_addr        = {st_addr[31:2], 2'b00};
            end
            STORE: begin
                mem_write_enable = st_store;
                mem_addr         = {st_addr[31:2], 2'b00};
                mem_write_data   = st_wdata;
            end
            RMW_WR: begin
                mem_write_enable = 1'b1;
                mem_addr         = {st_addr[31:2], 2'b00};
                mem_write_data   = merged_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = error_q;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem_read_enable ? mem[mem_addr[9:2]] : 32'h0;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;
        end else if (mem_write_enable) begin
            mem[mem_addr[9:2]] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge in IDLE; returns at #1 after an edge in the following IDLE.
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int exp_n, input logic exp_err, input logic [31:0] exp_rd,
                           input int exp_rc, input int exp_wc,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_wdat);
        int n = 0;
        int rc = 0;
        int wc = 0;
        logic err = 1'bx;
        logic [31:0] rd = 32'hx;
        logic [31:0] last_addr = 32'h0;
        logic [31:0] last_wd = 32'h0;
        req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin @(posedge clock); #1; end
            check({tag, " both_strobes"}, {31'b0, mem_read_enable & mem_write_enable}, 32'h0);
            if (mem_read_enable) begin rc++; last_addr = mem_addr; end
            if (mem_write_enable) begin wc++; last_addr = mem_addr; last_wd = mem_write_data; end
            if (resp_valid) begin n = c; err = resp_error; rd = resp_rdata; break; end
        end
        check({tag, " latency"}, 32'(n), 32'(exp_n));
        check({tag, " error"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " reads"}, 32'(rc), 32'(exp_rc));
        check({tag, " writes"}, 32'(wc), 32'(exp_wc));
        if (exp_rc + exp_wc > 0) check({tag, " mem_addr"}, last_addr, exp_maddr);
        if (exp_wc > 0) check({tag, " mem_wdata"}, last_wd, exp_wdat);
        @(posedge clock); #1;
        check({tag, " ready_after"}, {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        logic saw_resp;
        #2;
        check("rst req_ready", {31'b0, req_ready}, 32'h0);
        check("rst outputs", {29'b0, resp_valid, mem_read_enable, mem_write_enable}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        @(posedge clock); #2;
        preload = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle req_ready", {31'b0, req_ready}, 32'h1);
        check("idle resp_valid", {31'b0, resp_valid}, 32'h0);

        run_req("LW10",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h8899AABB, 1, 0, 32'h10, 32'h0);
        run_req("LB13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88, 1, 0, 32'h10, 32'h0);
        run_req("LBU13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 32'h00000088, 1, 0, 32'h10, 32'h0);
        run_req("LH12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8899, 1, 0, 32'h10, 32'h0);
        run_req("LHU10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 1'b0, 32'h0000AABB, 1, 0, 32'h10, 32'h0);
        run_req("LB10",  1'b0, 3'b000, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFFFBB, 1, 0, 32'h10, 32'h0);

        run_req("SB11",  1'b1, 3'b000, 32'h11, 32'h123456CC, 3, 1'b0, 32'h0, 1, 1, 32'h10, 32'h8899CCBB);
        run_req("LW10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h8899CCBB, 1, 0, 32'h10, 32'h0);
        run_req("SW14",  1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 2, 1'b0, 32'h0, 0, 1, 32'h14, 32'hDEADBEEF);
        check("mem word5", mem[5], 32'hDEADBEEF);

        run_req("SH11err",  1'b1, 3'b001, 32'h11,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
        run_req("LW402err", 1'b0, 3'b010, 32'h402, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
        run_req("LW400err", 1'b0, 3'b010, 32'h400, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
        run_req("S100err",  1'b1, 3'b100, 32'h10,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
        run_req("LW3FC",    1'b0, 3'b010, 32'h3FC, 32'h0, 2, 1'b0, 32'h0, 1, 0, 32'h3FC, 32'h0);

        // Reset during the RMW write cycle of an SH.
        req_is_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h7777; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("abort rmw_rd", {31'b0, mem_read_enable}, 32'h1);
        @(posedge clock); #1;
        check("abort rmw_wr", {31'b0, mem_write_enable}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort we_drop", {31'b0, mem_write_enable}, 32'h0);
        check("abort ready_rst", {31'b0, req_ready}, 32'h0);
        check("abort mem_addr", mem_addr, 32'h0);
        @(posedge clock); #3;
        reset = 1'b0;
        saw_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        check("abort no_resp", {31'b0, saw_resp}, 32'h0);
        check("abort mem unchanged", mem[4], 32'h8899CCBB);
        check("abort ready_after", {31'b0, req_ready}, 32'h1);

        // Two loads with req_valid held high throughout.
        req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clock); #1;
        check("b2b ready_load1", {31'b0, req_ready}, 32'h0);
        req_addr = 32'h14;
        @(posedge clock); #1;
        check("b2b ready_resp1", {31'b0, req_ready}, 32'h0);
        check("b2b resp1_valid", {31'b0, resp_valid}, 32'h1);
        check("b2b resp1_rdata", resp_rdata, 32'h8899CCBB);
        @(posedge clock); #1;
        check("b2b idle_ready", {31'b0, req_ready}, 32'h1);
        check("b2b idle_no_read", {31'b0, mem_read_enable}, 32'h0);
        @(posedge clock); #1;
        check("b2b ready_load2", {31'b0, req_ready}, 32'h0);
        check("b2b load2_addr", mem_addr, 32'h14);
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("b2b resp2_valid", {31'b0, resp_valid}, 32'h1);
        check("b2b resp2_rdata", resp_rdata, 32'hDEADBEEF);
        @(posedge clock); #1;
        check("b2b final_ready", {31'b0, req_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
